// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch controller: FSM state encoding,
// default reset/exception PCs, the sequential PC increment and the
// buffered {pc, instr} entry type.
package pc_fetch_pkg;

    typedef enum logic {
        ST_REQ  = 1'b0,   // normal fetch, responses are kept
        ST_DROP = 1'b1    // outstanding response belongs to a squashed path
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] PC_INC         = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus: instruction-memory request/response, IF->ID buffer head
// and the ID redirect path. The exc_req/eret_req/epc members exist only
// when PC_EXC_VECTOR_EN is defined.
interface pc_fetch_ctrl_if;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef PC_EXC_VECTOR_EN
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;

    modport master (
        output pc, imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ready, imem_rdata, id_ready, redirect_valid, redirect_pc,
               exc_req, eret_req, epc
    );
    modport slave (
        input  pc, imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ready, imem_rdata, id_ready, redirect_valid, redirect_pc,
               exc_req, eret_req, epc
    );
`else
    modport master (
        output pc, imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ready, imem_rdata, id_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  pc, imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ready, imem_rdata, id_ready, redirect_valid, redirect_pc
    );
`endif
endinterface

// File: rtl/pc_fetch_ctrl_fetch_buf.sv
// fetch_buf: 2-entry {pc, instr} FIFO between fetch and ID. The head is
// visible combinationally; push and pop may happen in the same cycle, and
// flush empties the buffer (an entry popped in that cycle still leaves).
module fetch_buf
    import pc_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         valid,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic [1:0]   cnt;

    // Storage and occupancy update; slot0 is always the head.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: storage is reset too, so the head reads as zero out of reset.
        if (reset) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) slot0 <= push_entry;
                    else             slot1 <= push_entry;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        slot0 <= push_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (cnt != 2'd0);
    assign head  = slot0;
    assign count = cnt;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the fetch PC, issues instruction-memory requests,
// buffers returned instructions for ID and applies ID redirects with a
// single MIPS delay slot. Defining PC_EXC_VECTOR_EN adds exception entry
// (EXC_VECTOR) and eret (epc) redirects that override everything else.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF
`ifdef PC_EXC_VECTOR_EN
   ,parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
)(
    input  logic            clk,
    input  logic            reset,
    pc_fetch_ctrl_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pending_q, pending_d;
    logic [31:0]  target_q, target_d;

    logic         buf_push, buf_pop, buf_flush, buf_valid;
    fetch_entry_t buf_head;
    logic [1:0]   buf_count;

    logic         req, resp, redirect_acc, trap_take;
    logic [31:0]  redirect_target, trap_pc;

    fetch_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (buf_push),
        .push_entry ({pc_q, bus.imem_rdata}),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .valid      (buf_valid),
        .head       (buf_head),
        .count      (buf_count)
    );

    // A request stays up while a squashed response is still owed, otherwise
    // only while the buffer has room for what comes back.
    assign req             = (state_q == ST_DROP) || (buf_count < 2'd2);
    assign resp            = req && bus.imem_ready;
    assign redirect_acc    = bus.redirect_valid && bus.id_ready;
    assign redirect_target = word_align(bus.redirect_pc);

`ifdef PC_EXC_VECTOR_EN
    assign trap_take = bus.exc_req || bus.eret_req;
    assign trap_pc   = bus.exc_req ? EXC_VECTOR : word_align(bus.epc);
`else
    assign trap_take = 1'b0;
    assign trap_pc   = '0;
`endif

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (reset) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            pending_q <= 1'b0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            target_q  <= target_d;
        end
    end

    // Next-state, next-PC and buffer controls for one fetch cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        target_d  = target_q;
        buf_push  = 1'b0;
        buf_pop   = 1'b0;
        buf_flush = 1'b0;

        if (trap_take) begin
            buf_flush = 1'b1;
            pending_d = 1'b0;
            pc_d      = trap_pc;
            state_d   = (req && !bus.imem_ready) ? ST_DROP : ST_REQ;
        end else if (redirect_acc && buf_valid) begin
            // Head leaves as the delay slot; everything younger is squashed,
            // including a response arriving this same cycle.
            buf_pop   = 1'b1;
            buf_flush = 1'b1;
            pending_d = 1'b0;
            pc_d      = redirect_target;
            state_d   = (req && !bus.imem_ready) ? ST_DROP : ST_REQ;
        end else begin
            buf_pop = buf_valid && bus.id_ready;
            if (state_q == ST_DROP) begin
                if (resp) state_d = ST_REQ;
            end else if (resp) begin
                buf_push  = 1'b1;
                pc_d      = pending_q ? target_q : pc_q + PC_INC;
                pending_d = 1'b0;
            end
            if (redirect_acc) begin
                // Buffer empty: the delay slot is the next kept response.
                if (state_q == ST_REQ && resp) begin
                    pc_d = redirect_target;
                end else begin
                    pending_d = 1'b1;
                    target_d  = redirect_target;
                end
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.imem_addr = pc_q;
    assign bus.imem_req  = req && !reset;
    assign bus.if_valid  = buf_valid;
    assign bus.if_pc     = buf_head.pc;
    assign bus.if_instr  = buf_head.instr;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: queue-based reference model with a
// per-cycle compare process, a latency-controlled instruction memory and
// directed scenarios with literal expectations. Exception scenarios run
// when PC_EXC_VECTOR_EN is defined.
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;
    import pc_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if bus();

    pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    int n_vec = 0;
    int n_err = 0;
    int lat   = 1;
    int wait_cnt = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory: answers a held request after 'lat' idle cycles with
    // a 1-cycle ready pulse carrying a word derived from the address.
    always @(negedge clk) begin
        if (rst || !bus.imem_req || bus.imem_ready) begin
            bus.imem_ready = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= lat) begin
            bus.imem_ready = 1'b1;
            bus.imem_rdata = instr_of(bus.imem_addr);
        end else begin
            wait_cnt++;
        end
    end

    // Reference model: fetched entries as a queue plus the fetch PC, a
    // "squashed response owed" flag and an unfetched-delay-slot redirect.
    fetch_entry_t mq[$];
    logic [31:0]  m_pc, m_tgt;
    bit           m_drop, m_pend;

    always @(posedge clk or posedge rst) begin : model
        bit          req, resp, acc, was_drop, trap;
        logic [31:0] tgt, trap_tgt;
        if (rst) begin
            mq.delete();
            m_pc = RST_PC; m_tgt = '0; m_drop = 0; m_pend = 0;
        end else begin
            req      = m_drop || (mq.size() < 2);
            resp     = req && bus.imem_ready;
            acc      = bus.redirect_valid && bus.id_ready;
            tgt      = {bus.redirect_pc[31:2], 2'b00};
            was_drop = m_drop;
            trap     = 0;
            trap_tgt = '0;
`ifdef PC_EXC_VECTOR_EN
            trap     = bus.exc_req || bus.eret_req;
            trap_tgt = bus.exc_req ? EXC_PC : {bus.epc[31:2], 2'b00};
`endif
            if (trap) begin
                mq.delete();
                m_pend = 0; m_pc = trap_tgt;
                m_drop = req && !bus.imem_ready;
            end else if (acc && mq.size() != 0) begin
                mq.delete();
                m_pc = tgt; m_pend = 0;
                m_drop = req && !bus.imem_ready;
            end else begin
                if (bus.id_ready && mq.size() != 0) void'(mq.pop_front());
                if (was_drop) begin
                    if (resp) m_drop = 0;
                end else if (resp) begin
                    mq.push_back(fetch_entry_t'{pc: m_pc, instr: bus.imem_rdata});
                    m_pc = m_pend ? m_tgt : m_pc + 32'd4;
                    m_pend = 0;
                end
                if (acc) begin
                    if (!was_drop && resp) m_pc = tgt;
                    else begin m_pend = 1; m_tgt = tgt; end
                end
            end
        end
    end

    // Compare process: every cycle out of reset, mid-way between edges.
    always @(negedge clk) begin
        if (!rst) begin
            check("pc", bus.pc, m_pc);
            check("imem_addr", bus.imem_addr, m_pc);
            check("imem_req", {31'd0, bus.imem_req}, {31'd0, (m_drop || mq.size() < 2)});
            check("if_valid", {31'd0, bus.if_valid}, {31'd0, (mq.size() != 0)});
            if (mq.size() != 0) begin
                check("if_pc", bus.if_pc, mq[0].pc);
                check("if_instr", bus.if_instr, mq[0].instr);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
`ifdef PC_EXC_VECTOR_EN
        bus.exc_req  = 1'b0;
        bus.eret_req = 1'b0;
        bus.epc      = '0;
`endif
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        idle_inputs();
        lat = 1;
        tick();
        check("rst_pc", bus.pc, RST_PC);
        check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_if_pc", bus.if_pc, 32'd0);
        check("rst_if_instr", bus.if_instr, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for a buffered head, check it, then pop it.
    task automatic expect_head(input logic [31:0] exp);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.if_valid) begin ok = 1; break; end
            tick();
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL head_timeout: no head seen, expected pc %h", exp);
        end else begin
            check("head_pc", bus.if_pc, exp);
            check("head_instr", bus.if_instr, instr_of(exp));
            bus.id_ready = 1'b1;
            tick();
            bus.id_ready = 1'b0;
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.id_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = target;
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();

        // Sequential fetch with ID stalled: two entries buffered, then drained in order.
        do_reset();
        repeat (8) tick();
        check("stall_req_low", {31'd0, bus.imem_req}, 32'd0);
        check("stall_pc", bus.pc, 32'h0000_3008);
        check("stall_head", bus.if_pc, 32'h0000_3000);
        expect_head(32'h0000_3000);
        expect_head(32'h0000_3004);
        expect_head(32'h0000_3008);
        expect_head(32'h0000_300C);

        // Delay slot in buffer, next fetch outstanding: slot kept, fetch dropped.
        do_reset();
        repeat (8) tick();
        lat = 60;
        expect_head(32'h0000_3000);
        tick();
        check("b_outstanding", {31'd0, bus.imem_req}, 32'd1);
        check("b_slot", bus.if_pc, 32'h0000_3004);
        redirect(32'h0000_3400);
        check("b_flushed", {31'd0, bus.if_valid}, 32'd0);
        check("b_addr", bus.imem_addr, 32'h0000_3400);
        lat = 1;
        expect_head(32'h0000_3400);
        expect_head(32'h0000_3404);

        // Buffer empty, delay slot still in flight: slot delivered, then target.
        do_reset();
        repeat (3) tick();
        lat = 60;
        check("c_first", bus.if_pc, 32'h0000_3000);
        expect_head(32'h0000_3000);
        check("c_empty", {31'd0, bus.if_valid}, 32'd0);
        redirect(32'h0000_3100);
        check("c_addr_hold", bus.imem_addr, 32'h0000_3004);
        lat = 1;
        expect_head(32'h0000_3004);
        expect_head(32'h0000_3100);
        expect_head(32'h0000_3104);

        // Empty buffer with the delay slot arriving in the redirect cycle; unaligned target.
        do_reset();
        tick(); tick();
        redirect(32'h0000_3102);
        check("d_pc_align", bus.pc, 32'h0000_3100);
        expect_head(32'h0000_3000);
        expect_head(32'h0000_3100);

        // Sequential fetch wraps past the top of the address space.
        do_reset();
        tick(); tick();
        redirect(32'hFFFF_FFF8);
        expect_head(32'h0000_3000);
        expect_head(32'hFFFF_FFF8);
        expect_head(32'hFFFF_FFFC);
        expect_head(32'h0000_0000);
        expect_head(32'h0000_0004);

`ifdef PC_EXC_VECTOR_EN
        // Exception with an entry buffered and a fetch outstanding, then eret.
        do_reset();
        repeat (3) tick();
        lat = 60;
        check("e_head", bus.if_pc, 32'h0000_3000);
        bus.exc_req = 1'b1;
        tick();
        bus.exc_req = 1'b0;
        check("e_flush", {31'd0, bus.if_valid}, 32'd0);
        check("e_addr", bus.imem_addr, EXC_PC);
        lat = 1;
        expect_head(EXC_PC);
        bus.eret_req = 1'b1; bus.epc = 32'h0000_3010;
        tick();
        bus.eret_req = 1'b0;
        expect_head(32'h0000_3010);
`endif

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
